// File: rtl/proc_ni_pkg.sv
// proc_ni_pkg: shared flit type codes, flit width helper and FSM state enums
// for the processor-side network interface.
// Ports: none (package).
package proc_ni_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  // A flit carries a 2-bit type code above the payload word.
  function automatic int flit_w(input int data_w);
    return data_w + 2;
  endfunction

  typedef enum logic {T_HEAD, T_TAIL} tx_state_t;
  typedef enum logic {R_HEAD, R_TAIL} rx_state_t;

endpackage

// File: rtl/proc_ni_fifo.sv
// proc_ni_fifo: synchronous FIFO with full/empty/count; front is the oldest entry.
// Ports: clk/rst (async active-high), push/push_data, pop, front, full, empty, count.
// A push while full and a pop while empty are ignored.
module proc_ni_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         front,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_ni.sv
// proc_ni: MIPS-side NoC interface. Outbound words are buffered and sent as
// head+tail packets; inbound head+tail packets become one word with valid/ready.
// Ports: clk, rst; proc_valid/dest_add/NI_in/mips_ni (outbound from CPU);
// data_valid/wd_NI/rx_src/proc_ready_in (inbound to CPU); tx_flit/tx_valid/tx_ready
// and rx_flit/rx_valid/rx_ready (router local port); err_cnt (malformed flits).
module proc_ni
  import proc_ni_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_valid,
  input  logic [ADDR_W-1:0] dest_add,
  input  logic [DATA_W-1:0] NI_in,
  output logic              mips_ni,
  output logic              data_valid,
  output logic [DATA_W-1:0] wd_NI,
  output logic [ADDR_W-1:0] rx_src,
  input  logic              proc_ready_in,
  output logic [DATA_W+1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W+1:0] rx_flit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        err_cnt
);

  localparam int                FW     = flit_w(DATA_W);
  localparam int                EW     = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] SRC_ID = ADDR_W'(NODE_ID);

  // ---------------- outbound path ----------------
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [EW-1:0]            fifo_front;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic [ADDR_W-1:0]        front_dest;
  logic [DATA_W-1:0]        front_data;
  logic [FW-1:0]            head_flit;
  logic [FW-1:0]            tail_flit;
  tx_state_t                tx_state;
  tx_state_t                tx_next;

  assign mips_ni   = !fifo_full;
  assign fifo_push = proc_valid && mips_ni;

  proc_ni_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({dest_add, NI_in}),
    .pop       (fifo_pop),
    .front     (fifo_front),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  assign front_dest = fifo_front[EW-1 -: ADDR_W];
  assign front_data = fifo_front[DATA_W-1:0];
  assign head_flit  = {FLIT_HEAD, {(DATA_W-2*ADDR_W){1'b0}}, SRC_ID, front_dest};
  assign tail_flit  = {FLIT_TAIL, front_data};

  // The FIFO front is only popped after the tail is taken, so the flit being
  // offered cannot change while the router stalls it.
  always_comb begin
    tx_next  = tx_state;
    tx_valid = 1'b0;
    tx_flit  = head_flit;
    fifo_pop = 1'b0;
    case (tx_state)
      T_HEAD: begin
        tx_valid = !fifo_empty;
        if (!fifo_empty && tx_ready) tx_next = T_TAIL;
      end
      T_TAIL: begin
        tx_valid = 1'b1;
        tx_flit  = tail_flit;
        if (tx_ready) begin
          fifo_pop = 1'b1;
          tx_next  = T_HEAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_HEAD;
    else     tx_state <= tx_next;
  end

  // ---------------- inbound path ----------------
  rx_state_t         rx_state;
  rx_state_t         rx_next;
  logic [1:0]        rx_type;
  logic              rx_acc;
  logic              latch_src;
  logic              load_word;
  logic              err_inc;
  logic [ADDR_W-1:0] pend_src;

  assign rx_type = rx_flit[FW-1 -: 2];
  // While waiting for a tail, only take it if the output slot is free or
  // being drained this cycle; heads are always accepted.
  assign rx_ready = (rx_state == R_HEAD) ? 1'b1 : (!data_valid || proc_ready_in);
  assign rx_acc   = rx_valid && rx_ready;

  always_comb begin
    rx_next   = rx_state;
    latch_src = 1'b0;
    load_word = 1'b0;
    err_inc   = 1'b0;
    case (rx_state)
      R_HEAD: begin
        if (rx_acc) begin
          if (rx_type == FLIT_HEAD) begin
            latch_src = 1'b1;
            rx_next   = R_TAIL;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      R_TAIL: begin
        if (rx_acc) begin
          if (rx_type == FLIT_TAIL) begin
            load_word = 1'b1;
            rx_next   = R_HEAD;
          end else if (rx_type == FLIT_HEAD) begin
            // A new head abandons the packet in progress.
            latch_src = 1'b1;
            err_inc   = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= R_HEAD;
      pend_src   <= '0;
      data_valid <= 1'b0;
      wd_NI      <= '0;
      rx_src     <= '0;
      err_cnt    <= '0;
    end else begin
      rx_state <= rx_next;
      if (latch_src) pend_src <= rx_flit[2*ADDR_W-1:ADDR_W];
      if (load_word) begin
        data_valid <= 1'b1;
        wd_NI      <= rx_flit[DATA_W-1:0];
        rx_src     <= pend_src;
      end else if (proc_ready_in) begin
        data_valid <= 1'b0;
      end
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_ni.sv
// tb_proc_ni: directed vector table plus hand-written sequences for
// backpressure, saturation, mid-packet reset and a randomized loopback run.
module tb_proc_ni;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          proc_valid = 1'b0;
  logic [AW-1:0] dest_add = '0;
  logic [DW-1:0] NI_in = '0;
  logic          mips_ni;
  logic          data_valid;
  logic [DW-1:0] wd_NI;
  logic [AW-1:0] rx_src;
  logic          proc_ready_in = 1'b0;
  logic [DW+1:0] tx_flit;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [DW+1:0] rx_flit = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  proc_ni #(.DATA_W(DW), .ADDR_W(AW), .NODE_ID(0), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .proc_valid    (proc_valid),
    .dest_add      (dest_add),
    .NI_in         (NI_in),
    .mips_ni       (mips_ni),
    .data_valid    (data_valid),
    .wd_NI         (wd_NI),
    .rx_src        (rx_src),
    .proc_ready_in (proc_ready_in),
    .tx_flit       (tx_flit),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_flit       (rx_flit),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .err_cnt       (err_cnt)
  );

  typedef struct {
    logic          pv;
    logic [1:0]    dest;
    logic [31:0]   ni;
    logic          txr;
    logic [33:0]   rxf;
    logic          rxv;
    logic          prdy;
    logic          e_mips;
    logic          e_txv;
    logic [33:0]   e_flit;
    logic          e_dv;
    logic [31:0]   e_wd;
    logic [1:0]    e_src;
    logic          e_rxr;
    logic [7:0]    e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [33:0] head_f(input logic [1:0] d, input logic [1:0] s);
    return {2'b01, 28'd0, s, d};
  endfunction

  function automatic logic [33:0] tail_f(input logic [31:0] w);
    return {2'b10, w};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_v(input logic pv, input logic [1:0] dest, input logic [31:0] ni,
                       input logic txr, input logic [33:0] rxf, input logic rxv, input logic prdy,
                       input logic e_mips, input logic e_txv, input logic [33:0] e_flit,
                       input logic e_dv, input logic [31:0] e_wd, input logic [1:0] e_src,
                       input logic e_rxr, input logic [7:0] e_err);
    vec_t v;
    v.pv = pv; v.dest = dest; v.ni = ni; v.txr = txr; v.rxf = rxf; v.rxv = rxv; v.prdy = prdy;
    v.e_mips = e_mips; v.e_txv = e_txv; v.e_flit = e_flit; v.e_dv = e_dv; v.e_wd = e_wd;
    v.e_src = e_src; v.e_rxr = e_rxr; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    proc_valid = 1'b0; dest_add = '0; NI_in = '0; tx_ready = 1'b0;
    rx_flit = '0; rx_valid = 1'b0; proc_ready_in = 1'b0;
  endtask

  initial begin
    logic [33:0] exp_fl [8];
    logic [33:0] pf_prev;
    logic        pv_prev;
    logic        pr_prev;
    int          nacc;
    logic [31:0] q[$];
    int          sent;
    int          got;
    int          cyc;
    logic        g;

    // pv dest ni txr rxf rxv prdy | mips txv flit dv wd src rxr err
    add_v(0,0,0,0,0,0,0,                       1,0,0,0,0,0,1,0);
    add_v(1,2,32'hDEADBEEF,1,0,0,0,            1,0,0,0,0,0,1,0);
    add_v(0,0,0,1,0,0,0,                       1,1,head_f(2,0),0,0,0,1,0);
    add_v(0,0,0,1,0,0,0,                       1,1,tail_f(32'hDEADBEEF),0,0,0,1,0);
    add_v(0,0,0,1,0,0,0,                       1,0,0,0,0,0,1,0);
    add_v(0,0,0,0,head_f(0,3),1,0,             1,0,0,0,0,0,1,0);
    add_v(0,0,0,0,tail_f(32'h12345678),1,0,    1,0,0,0,0,0,1,0);
    add_v(0,0,0,0,head_f(0,1),1,0,             1,0,0,1,32'h12345678,3,1,0);
    add_v(0,0,0,0,tail_f(32'hCAFEF00D),1,0,    1,0,0,1,32'h12345678,3,0,0);
    add_v(0,0,0,0,tail_f(32'hCAFEF00D),1,1,    1,0,0,1,32'h12345678,3,1,0);
    add_v(0,0,0,0,0,0,0,                       1,0,0,1,32'hCAFEF00D,1,1,0);
    add_v(0,0,0,0,0,0,1,                       1,0,0,1,32'hCAFEF00D,1,1,0);
    add_v(0,0,0,0,0,0,0,                       1,0,0,0,32'hCAFEF00D,1,1,0);
    add_v(0,0,0,0,tail_f(32'h55),1,0,          1,0,0,0,32'hCAFEF00D,1,1,0);
    add_v(0,0,0,0,head_f(0,1),1,0,             1,0,0,0,32'hCAFEF00D,1,1,1);
    add_v(0,0,0,0,head_f(0,2),1,0,             1,0,0,0,32'hCAFEF00D,1,1,1);
    add_v(0,0,0,0,tail_f(32'h1),1,0,           1,0,0,0,32'hCAFEF00D,1,1,2);
    add_v(0,0,0,0,0,0,1,                       1,0,0,1,32'h1,2,1,2);
    add_v(0,0,0,0,{2'b11,32'h9},1,0,           1,0,0,0,32'h1,2,1,2);
    add_v(0,0,0,0,{2'b00,32'h9},1,0,           1,0,0,0,32'h1,2,1,3);
    add_v(0,0,0,0,0,0,0,                       1,0,0,0,32'h1,2,1,4);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // ---- table ----
    foreach (vecs[i]) begin
      proc_valid = vecs[i].pv; dest_add = vecs[i].dest; NI_in = vecs[i].ni;
      tx_ready = vecs[i].txr; rx_flit = vecs[i].rxf; rx_valid = vecs[i].rxv;
      proc_ready_in = vecs[i].prdy;
      #1;
      chk($sformatf("v%0d_mips", i), mips_ni, vecs[i].e_mips);
      chk($sformatf("v%0d_txv", i), tx_valid, vecs[i].e_txv);
      if (vecs[i].e_txv) chk($sformatf("v%0d_flit", i), tx_flit, vecs[i].e_flit);
      chk($sformatf("v%0d_dv", i), data_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_wd", i), wd_NI, vecs[i].e_wd);
      chk($sformatf("v%0d_src", i), rx_src, vecs[i].e_src);
      chk($sformatf("v%0d_rxr", i), rx_ready, vecs[i].e_rxr);
      chk($sformatf("v%0d_err", i), err_cnt, vecs[i].e_err);
      step();
    end
    idle_inputs();

    // ---- backpressure: 5 offers with router stalled, 4 accepted ----
    for (int i = 0; i < 5; i++) begin
      proc_valid = 1'b1; dest_add = 2'(i); NI_in = 32'hA000_0000 + i;
      #1;
      chk($sformatf("bp_mips%0d", i), mips_ni, (i < 4) ? 1'b1 : 1'b0);
      step();
    end
    proc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_fl[2*k]   = head_f(2'(k), 2'd0);
      exp_fl[2*k+1] = tail_f(32'hA000_0000 + k);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall", {tx_valid, tx_flit}, {1'b1, exp_fl[0]});
      step();
    end
    nacc = 0; pv_prev = 1'b0; pr_prev = 1'b0; pf_prev = '0;
    for (int c = 0; c < 60 && nacc < 8; c++) begin
      tx_ready = ((c % 3) != 2);
      #1;
      if (pv_prev && !pr_prev) chk("bp_hold", {tx_valid, tx_flit}, {1'b1, pf_prev});
      if (tx_valid && tx_ready) begin
        chk($sformatf("bp_flit%0d", nacc), tx_flit, exp_fl[nacc]);
        nacc++;
      end
      pv_prev = tx_valid; pr_prev = tx_ready; pf_prev = tx_flit;
      step();
    end
    tx_ready = 1'b0;
    #1;
    chk("bp_count", nacc, 8);
    chk("bp_drained", {tx_valid, mips_ni}, 2'b01);

    // ---- saturation with stray tails ----
    rx_flit = tail_f(32'h7); rx_valid = 1'b1;
    repeat (300) step();
    #1;
    chk("sat_err", err_cnt, 8'd255);
    step();
    #1;
    chk("sat_hold", err_cnt, 8'd255);
    idle_inputs();
    step();

    // ---- reset mid-packet on both sides ----
    proc_valid = 1'b1; dest_add = 2'd1; NI_in = 32'h77;
    rx_flit = head_f(0, 3); rx_valid = 1'b1;
    step();
    proc_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    #1;
    chk("rst_pre_tail", {tx_valid, tx_flit}, {1'b1, tail_f(32'h77)});
    rst = 1'b1;
    #1;
    chk("rst_mips", mips_ni, 1'b1);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_rxr", rx_ready, 1'b1);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_wd_src", {wd_NI, rx_src}, '0);
    chk("rst_err", err_cnt, 8'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_fifo_empty", tx_valid, 1'b0);
    proc_valid = 1'b1; dest_add = 2'd3; NI_in = 32'h99;
    rx_flit = tail_f(32'h5); rx_valid = 1'b1;   // stray tail after reset: error
    step();
    proc_valid = 1'b0; tx_ready = 1'b1; rx_flit = head_f(0, 1);
    #1;
    chk("post_head", {tx_valid, tx_flit}, {1'b1, head_f(3, 0)});
    step();
    rx_flit = tail_f(32'hBEEF);
    #1;
    chk("post_tail", {tx_valid, tx_flit}, {1'b1, tail_f(32'h99)});
    step();
    idle_inputs();
    #1;
    chk("post_rx", {data_valid, wd_NI, rx_src}, {1'b1, 32'hBEEF, 2'd1});
    chk("post_err", err_cnt, 8'd1);
    chk("post_txv", tx_valid, 1'b0);
    proc_ready_in = 1'b1;
    step();
    idle_inputs();

    // ---- randomized loopback ----
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      proc_valid    = (sent < 1000) && ($urandom_range(0, 3) != 0);
      NI_in         = $urandom;
      dest_add      = 2'($urandom_range(0, 3));
      proc_ready_in = ($urandom_range(0, 2) != 0);
      g             = ($urandom_range(0, 3) != 0);
      #1;
      rx_flit  = tx_flit;
      rx_valid = tx_valid && g;
      tx_ready = rx_ready && g;
      #1;
      if (proc_valid && mips_ni) begin
        q.push_back(NI_in);
        sent++;
      end
      if (data_valid && proc_ready_in) begin
        if (q.size() == 0) begin
          chk("st_extra", 1, 0);
        end else begin
          chk($sformatf("st_word%0d", got), {rx_src, wd_NI}, {2'd0, q[0]});
          void'(q.pop_front());
        end
        got++;
      end
      cyc++;
      step();
    end
    idle_inputs();
    #1;
    chk("st_delivered", got, 1000);
    chk("st_sent", sent, 1000);
    chk("st_err", err_cnt, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
